// File: rtl/mult_pipe.sv
// mult_pipe: pipelined integer multiplier for the execute stage.
// Stage 0 forms the full 2*XLEN product, later stages are plain delay
// registers that synthesis may retime. Each stage carries its own valid bit,
// so a stalled output lets upstream bubbles collapse before issue is blocked.

package mult_pipe_pkg;

    typedef enum logic [3:0] {
        ADD    = 4'd0,
        SUB    = 4'd1,
        MUL    = 4'd2,
        MULH   = 4'd3,
        MULHU  = 4'd4,
        MULHSU = 4'd5,
        MULW   = 4'd6,
        DIV    = 4'd7
    } fu_op;

endpackage

module mult_pipe
    import mult_pipe_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int NrStages    = 2,
    parameter int TransIdBits = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   mult_valid_i,
    input  fu_op                   operator_i,
    input  logic [TransIdBits-1:0] trans_id_i,
    input  logic [XLEN-1:0]        operand_a_i,
    input  logic [XLEN-1:0]        operand_b_i,
    output logic                   mult_ready_o,
    output logic                   mult_valid_o,
    output logic [XLEN-1:0]        result_o,
    output logic [TransIdBits-1:0] mult_trans_id_o,
    input  logic                   result_ack_i
);

    localparam int PW = 2 * XLEN;

    logic [NrStages-1:0]    stage_valid;
    logic [NrStages-1:0]    stage_en;
    logic [TransIdBits-1:0] stage_id   [NrStages];
    fu_op                   stage_op   [NrStages];
    logic [PW-1:0]          stage_prod [NrStages];

    logic          op_legal;
    logic          sign_a;
    logic          sign_b;
    logic          accept;
    logic [PW-1:0] a_wide;
    logic [PW-1:0] b_wide;
    logic [PW-1:0] product;
    logic [PW-1:0] last_prod;

    // Decode which operators this unit executes and how each operand is extended
    always_comb begin
        op_legal = 1'b0;
        case (operator_i)
            MUL, MULH, MULHU, MULHSU: op_legal = 1'b1;
            MULW:                     op_legal = (XLEN == 64);
            default:                  op_legal = 1'b0;
        endcase
        sign_a = (operator_i == MULH) || (operator_i == MULHSU);
        sign_b = (operator_i == MULH);
    end

    assign accept = mult_valid_i && stage_en[0] && !flush_i && op_legal;

    // Extending straight to 2*XLEN gives the same low 2*XLEN bits as an
    // (XLEN+1)x(XLEN+1) signed product truncated to 2*XLEN
    always_comb begin
        a_wide  = {{XLEN{sign_a & operand_a_i[XLEN-1]}}, operand_a_i};
        b_wide  = {{XLEN{sign_b & operand_b_i[XLEN-1]}}, operand_b_i};
        product = a_wide * b_wide;
    end

    // Enables ripple back from the writeback ack so bubbles collapse under stall
    always_comb begin
        stage_en = '0;
        stage_en[NrStages-1] = !stage_valid[NrStages-1] || result_ack_i;
        for (int i = NrStages - 2; i >= 0; i--) begin
            stage_en[i] = !stage_valid[i] || stage_en[i+1];
        end
    end

    assign mult_ready_o = stage_en[0];

    // Valid bits advance with the enables; flush empties the whole pipeline
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_valid <= '0;
        end else if (flush_i) begin
            stage_valid <= '0;
        end else begin
            if (stage_en[0]) begin
                stage_valid[0] <= accept;
            end
            for (int i = 1; i < NrStages; i++) begin
                if (stage_en[i]) begin
                    stage_valid[i] <= stage_valid[i-1];
                end
            end
        end
    end

    // Payload only moves with a real op, so the output keeps the last result during bubbles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrStages; i++) begin
                stage_id[i]   <= '0;
                stage_op[i]   <= MUL;
                stage_prod[i] <= '0;
            end
        end else begin
            if (stage_en[0] && accept) begin
                stage_id[0]   <= trans_id_i;
                stage_op[0]   <= operator_i;
                stage_prod[0] <= product;
            end
            for (int i = 1; i < NrStages; i++) begin
                if (stage_en[i] && stage_valid[i-1]) begin
                    stage_id[i]   <= stage_id[i-1];
                    stage_op[i]   <= stage_op[i-1];
                    stage_prod[i] <= stage_prod[i-1];
                end
            end
        end
    end

    // Pick the result half (or the sign-extended word) from the last stage
    always_comb begin
        last_prod = stage_prod[NrStages-1];
        case (stage_op[NrStages-1])
            MULH, MULHU, MULHSU: result_o = last_prod[PW-1:XLEN];
            MULW:                result_o = XLEN'($signed(last_prod[31:0]));
            default:             result_o = last_prod[XLEN-1:0];
        endcase
    end

    assign mult_valid_o    = stage_valid[NrStages-1];
    assign mult_trans_id_o = stage_id[NrStages-1];

endmodule

// File: tb/tb_mult_pipe.sv
// tb_mult_pipe: scoreboard bench for mult_pipe (XLEN=64, three stages).
// The driver pushes the expected result of every accepted op into a queue;
// an independent monitor pops and compares whenever a result is consumed.

module tb_mult_pipe;
    import mult_pipe_pkg::*;

    localparam int XLEN      = 64;
    localparam int NR_STAGES = 3;
    localparam int ID_BITS   = 3;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic               flush_i = 1'b0;
    logic               mult_valid_i = 1'b0;
    fu_op               operator_i = MUL;
    logic [ID_BITS-1:0] trans_id_i = '0;
    logic [XLEN-1:0]    operand_a_i = '0;
    logic [XLEN-1:0]    operand_b_i = '0;
    logic               mult_ready_o;
    logic               mult_valid_o;
    logic [XLEN-1:0]    result_o;
    logic [ID_BITS-1:0] mult_trans_id_o;
    logic               result_ack_i = 1'b0;

    typedef struct packed {
        logic [ID_BITS-1:0] id;
        logic [XLEN-1:0]    res;
    } exp_t;

    exp_t               sb[$];
    exp_t               mon_exp;
    int                 pass_cnt = 0;
    int                 total_cnt = 0;
    int                 accept_cnt = 0;
    bit                 ack_random = 1'b0;
    bit                 stall_seen = 1'b0;
    logic [XLEN-1:0]    held_res = '0;
    logic [ID_BITS-1:0] held_id = '0;

    mult_pipe #(
        .XLEN        (XLEN),
        .NrStages    (NR_STAGES),
        .TransIdBits (ID_BITS)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .mult_valid_i    (mult_valid_i),
        .operator_i      (operator_i),
        .trans_id_i      (trans_id_i),
        .operand_a_i     (operand_a_i),
        .operand_b_i     (operand_b_i),
        .mult_ready_o    (mult_ready_o),
        .mult_valid_o    (mult_valid_o),
        .result_o        (result_o),
        .mult_trans_id_o (mult_trans_id_o),
        .result_ack_i    (result_ack_i)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk_i = ~clk_i;

    // Reference model: plain 128-bit modular arithmetic on extended operands
    function automatic logic [XLEN-1:0] ref_result(input fu_op op, input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic [127:0] ua, ub, sa, sbv, p;
        ua  = {64'd0, a};
        ub  = {64'd0, b};
        sa  = {{64{a[63]}}, a};
        sbv = {{64{b[63]}}, b};
        case (op)
            MULHU:   begin p = ua * ub;  return p[127:64]; end
            MULH:    begin p = sa * sbv; return p[127:64]; end
            MULHSU:  begin p = sa * ub;  return p[127:64]; end
            MULW:    begin p = ua * ub;  return {{32{p[31]}}, p[31:0]}; end
            default: begin p = ua * ub;  return p[63:0]; end
        endcase
    endfunction

    task automatic check_output(input string name, input logic [XLEN-1:0] actual,
                                input logic [XLEN-1:0] expected);
        total_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        total_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    endtask

    // Present one op, wait (bounded) for ready, and record its expected result on acceptance
    task automatic apply_stimulus(input fu_op op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                  input logic [ID_BITS-1:0] id, input bit flush,
                                  input bit use_exp, input logic [XLEN-1:0] exp_val);
        int   waited;
        bit   legal;
        exp_t e;
        waited       = 0;
        mult_valid_i = 1'b1;
        operator_i   = op;
        operand_a_i  = a;
        operand_b_i  = b;
        trans_id_i   = id;
        flush_i      = flush;
        @(negedge clk_i);
        while (!mult_ready_o && !flush) begin
            waited++;
            if (waited > 200) begin
                check_bit("ready_timeout", mult_ready_o, 1'b1);
                break;
            end
            @(negedge clk_i);
        end
        @(posedge clk_i);
        legal = (op == MUL) || (op == MULH) || (op == MULHU) || (op == MULHSU) || (op == MULW);
        if (legal && !flush && waited <= 200) begin
            e.id  = id;
            e.res = use_exp ? exp_val : ref_result(op, a, b);
            sb.push_back(e);
            accept_cnt++;
        end
        #1;
        mult_valid_i = 1'b0;
        flush_i      = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check_output("drain_empty", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk_i);
    endtask

    // Monitor: pop and compare on every consumed result, and check held outputs under stall
    always @(negedge clk_i) begin
        if (rst_ni && !flush_i) begin
            if (stall_seen) begin
                check_bit("stall_valid_held", mult_valid_o, 1'b1);
                check_output("stall_result_held", result_o, held_res);
                check_output("stall_id_held", 64'(mult_trans_id_o), 64'(held_id));
            end
            if (mult_valid_o && result_ack_i) begin
                if (sb.size() == 0) begin
                    check_bit("spurious_result", mult_valid_o, 1'b0);
                end else begin
                    mon_exp = sb.pop_front();
                    check_output("result_id", 64'(mult_trans_id_o), 64'(mon_exp.id));
                    check_output("result_value", result_o, mon_exp.res);
                end
            end
        end
        stall_seen = rst_ni && !flush_i && mult_valid_o && !result_ack_i;
        held_res   = result_o;
        held_id    = mult_trans_id_o;
    end

    // Random writeback backpressure during the random phase
    always @(posedge clk_i) begin
        if (ack_random) begin
            #1;
            result_ack_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Hard time limit so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int n;
        logic [XLEN-1:0] ra, rb;

        // Reset state
        #1;
        check_bit("reset_valid", mult_valid_o, 1'b0);
        check_output("reset_result", result_o, 64'd0);
        check_output("reset_id", 64'(mult_trans_id_o), 64'd0);
        check_bit("reset_ready", mult_ready_o, 1'b1);
        #21 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        result_ack_i = 1'b1;

        // Latency: valid only in cycle 3 after acceptance
        apply_stimulus(MUL, 64'd3, 64'd5, 3'd2, 1'b0, 1'b1, 64'd15);
        @(negedge clk_i);
        check_bit("lat_cycle1_valid", mult_valid_o, 1'b0);
        @(negedge clk_i);
        check_bit("lat_cycle2_valid", mult_valid_o, 1'b0);
        @(negedge clk_i);
        check_bit("lat_cycle3_valid", mult_valid_o, 1'b1);
        check_output("lat_cycle3_result", result_o, 64'd15);
        check_output("lat_cycle3_id", 64'(mult_trans_id_o), 64'd2);
        @(negedge clk_i);
        check_bit("lat_cycle4_valid", mult_valid_o, 1'b0);
        @(posedge clk_i);
        #1;

        // High-half and word modes against known answers
        apply_stimulus(MULH, '1, '1, 3'd1, 1'b0, 1'b1, 64'd0);
        apply_stimulus(MULHU, '1, '1, 3'd2, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        apply_stimulus(MULHSU, '1, 64'd2, 3'd3, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        apply_stimulus(MULW, 64'h7FFF_FFFF, 64'd2, 3'd4, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        wait_drain();

        // Backpressure: five back-to-back issues with writeback stalled
        @(posedge clk_i);
        #1;
        result_ack_i = 1'b0;
        base = accept_cnt;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    apply_stimulus(MUL, 64'(i + 10), 64'd7, 3'(i), 1'b0, 1'b0, 64'd0);
                end
            end
            begin
                n = 0;
                while (accept_cnt < base + 3 && n < 20) begin
                    @(negedge clk_i);
                    n++;
                end
                @(negedge clk_i);
                check_bit("bp_ready_low_when_full", mult_ready_o, 1'b0);
                check_bit("bp_output_valid", mult_valid_o, 1'b1);
                check_output("bp_output_id", 64'(mult_trans_id_o), 64'd0);
                repeat (4) @(negedge clk_i);
                check_output("bp_held_off", 64'(accept_cnt - base), 64'd3);
                @(posedge clk_i);
                #2;
                result_ack_i = 1'b1;
                #1;
                check_bit("bp_ready_same_cycle", mult_ready_o, 1'b1);
            end
        join
        wait_drain();

        // Non-multiply operator is ignored; following MUL unaffected
        apply_stimulus(ADD, 64'd9, 64'd9, 3'd5, 1'b0, 1'b0, 64'd0);
        apply_stimulus(MUL, 64'd6, 64'd7, 3'd6, 1'b0, 1'b1, 64'd42);
        wait_drain();

        // Flush with three ops in flight plus a new issue in the flush cycle
        apply_stimulus(MUL, 64'd11, 64'd2, 3'd1, 1'b0, 1'b0, 64'd0);
        apply_stimulus(MULHU, 64'd12, 64'd3, 3'd2, 1'b0, 1'b0, 64'd0);
        apply_stimulus(MUL, 64'd13, 64'd4, 3'd3, 1'b0, 1'b0, 64'd0);
        apply_stimulus(MUL, 64'd14, 64'd5, 3'd4, 1'b1, 1'b0, 64'd0);
        sb.delete();
        @(negedge clk_i);
        check_bit("flush_valid_cleared", mult_valid_o, 1'b0);
        check_bit("flush_ready", mult_ready_o, 1'b1);
        @(posedge clk_i);
        #1;
        apply_stimulus(MUL, 64'd100, 64'd3, 3'd7, 1'b0, 1'b1, 64'd300);
        wait_drain();

        // Asynchronous reset with two ops in flight
        apply_stimulus(MUL, 64'd21, 64'd2, 3'd1, 1'b0, 1'b0, 64'd0);
        apply_stimulus(MUL, 64'd22, 64'd2, 3'd2, 1'b0, 1'b0, 64'd0);
        #3 rst_ni = 1'b0;
        #1;
        check_bit("arst_valid", mult_valid_o, 1'b0);
        check_output("arst_result", result_o, 64'd0);
        check_output("arst_id", 64'(mult_trans_id_o), 64'd0);
        check_bit("arst_ready", mult_ready_o, 1'b1);
        sb.delete();
        #7 rst_ni = 1'b1;
        repeat (6) @(negedge clk_i);
        check_bit("arst_no_stale", mult_valid_o, 1'b0);

        // Randomized mix of operators, operands and writeback backpressure
        @(posedge clk_i);
        #1;
        ack_random = 1'b1;
        for (int i = 0; i < 150; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) ra = '1;
            if ($urandom_range(0, 7) == 0) rb = {1'b1, 63'd0};
            apply_stimulus(fu_op'(4'($urandom_range(0, 7))), ra, rb, 3'($urandom_range(0, 7)),
                           1'b0, 1'b0, 64'd0);
        end
        ack_random = 1'b0;
        @(posedge clk_i);
        #2;
        result_ack_i = 1'b1;
        wait_drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
